// File: rtl/timer_tick_master_if.sv
// Shared memory-mapped bus between the tick master and the cycle timer.
// The master drives address/data/strobes; the timer returns cycle data and its interrupt.
interface timer_tick_master_if;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] cycle;
    logic        MemRead;
    logic        MemWrite;
    logic        TimerInterrupt;

    // Strobes are single-cycle and mutually exclusive; the timer samples writes
    // on the rising edge and returns read data in the same cycle as MemRead.
    modport master (
        output address, data, MemRead, MemWrite,
        input  cycle, TimerInterrupt
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output cycle, TimerInterrupt
    );
endinterface

// File: rtl/timer_tick_master.sv
// Bus initiator that re-arms the cycle timer every PERIOD cycles without drift,
// acknowledging each timer interrupt and counting ticks.
module timer_tick_master #(
    parameter logic [31:0] PERIOD     = 32'd100,
    parameter logic [31:0] CYCLE_ADDR = 32'hffff001c,
    parameter logic [31:0] ACK_ADDR   = 32'hffff006c
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    timer_tick_master_if.master  bus,
    output logic [31:0]          tick_count,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] ARM  = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] ACK  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] now_q, now_d;
    logic [31:0] target_q, target_d;
    logic        armed_q, armed_d;
    logic [31:0] tick_q, tick_d;
    logic        overrun_q, overrun_d;

    logic [31:0] cand;
    logic [31:0] diff;
    logic        late;
    logic [31:0] next_val;

    // Signed distance from "now" to the candidate target survives counter wrap.
    assign cand     = target_q + PERIOD;
    assign diff     = cand - now_q;
    assign late     = diff[31] || (diff == 32'd0);
    assign next_val = (!armed_q || late) ? (now_q + PERIOD) : cand;

    always_comb begin
        state_d   = state_q;
        now_d     = now_q;
        target_d  = target_q;
        armed_d   = armed_q;
        tick_d    = tick_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: if (enable) state_d = READ;
            READ: begin
                now_d   = bus.cycle;
                state_d = ARM;
            end
            ARM: begin
                target_d = next_val;
                armed_d  = 1'b1;
                if (armed_q && late) overrun_d = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (bus.TimerInterrupt) begin
                    state_d = ACK;
                end else if (!enable) begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end
            end
            ACK: begin
                tick_d = tick_q + 32'd1;
                if (enable) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                    armed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            now_q     <= 32'd0;
            target_q  <= 32'd0;
            armed_q   <= 1'b0;
            tick_q    <= 32'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            now_q     <= now_d;
            target_q  <= target_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        bus.address  = 32'd0;
        bus.data     = 32'd0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        case (state_q)
            READ: begin
                bus.address = CYCLE_ADDR;
                bus.MemRead = 1'b1;
            end
            ARM: begin
                bus.address  = CYCLE_ADDR;
                bus.data     = next_val;
                bus.MemWrite = 1'b1;
            end
            ACK: begin
                bus.address  = ACK_ADDR;
                bus.MemWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign tick_count = tick_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master: one DUT at PERIOD=100, a second at PERIOD=4
// for the late-target cases.
module tb_timer_tick_master;

    localparam logic [31:0] CYC = 32'hffff001c;
    localparam logic [31:0] AKA = 32'hffff006c;

    logic        clock;
    logic        reset;
    logic        enable1, enable2;
    logic [31:0] tick1, tick2;
    logic        ovr1, ovr2;
    logic        busy1, busy2;
    logic [2:0]  st1, st2;
    int          n_cmp;
    int          n_err;

    timer_tick_master_if bus1 ();
    timer_tick_master_if bus2 ();

    timer_tick_master #(.PERIOD(32'd100)) dut1 (
        .clock(clock), .reset(reset), .enable(enable1), .bus(bus1),
        .tick_count(tick1), .overrun(ovr1), .busy(busy1), .state_dbg(st1)
    );

    timer_tick_master #(.PERIOD(32'd4)) dut2 (
        .clock(clock), .reset(reset), .enable(enable2), .bus(bus2),
        .tick_count(tick2), .overrun(ovr2), .busy(busy2), .state_dbg(st2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus1.address !== 32'd0) begin n_err++; $display("FAIL reset_address: got %h want 0", bus1.address); end
        n_cmp++; if (bus1.MemRead !== 1'b0 || bus1.MemWrite !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got r=%b w=%b want 0/0", bus1.MemRead, bus1.MemWrite); end
        n_cmp++; if (tick1 !== 32'd0 || ovr1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL reset_status: got tick=%0d ovr=%b busy=%b want 0/0/0", tick1, ovr1, busy1); end
        step();
        reset = 1'b1;
        step();
        n_cmp++; if (st1 !== 3'd0) begin n_err++; $display("FAIL reset_idle: got state %0d want 0", st1); end
    endtask

    task automatic test_start();
        enable1 = 1'b1;
        bus1.cycle = 32'd50;
        step();
        n_cmp++; if (bus1.MemRead !== 1'b1 || bus1.MemWrite !== 1'b0 || bus1.address !== CYC) begin n_err++; $display("FAIL start_read: got r=%b w=%b addr=%h want 1/0/%h", bus1.MemRead, bus1.MemWrite, bus1.address, CYC); end
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", busy1); end
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.MemRead !== 1'b0 || bus1.address !== CYC) begin n_err++; $display("FAIL start_arm_strobe: got r=%b w=%b addr=%h", bus1.MemRead, bus1.MemWrite, bus1.address); end
        n_cmp++; if (bus1.data !== 32'd150) begin n_err++; $display("FAIL start_arm_data: got %0d want 150", bus1.data); end
        step();
        n_cmp++; if (st1 !== 3'd3 || bus1.MemWrite !== 1'b0 || bus1.MemRead !== 1'b0) begin n_err++; $display("FAIL start_wait: got state=%0d r=%b w=%b want 3/0/0", st1, bus1.MemRead, bus1.MemWrite); end
    endtask

    task automatic test_interrupt();
        step();
        step();
        n_cmp++; if (st1 !== 3'd3 || bus1.MemWrite !== 1'b0) begin n_err++; $display("FAIL irq_idle_wait: got state=%0d w=%b want 3/0", st1, bus1.MemWrite); end
        bus1.TimerInterrupt = 1'b1;
        bus1.cycle = 32'd150;
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.address !== AKA || bus1.data !== 32'd0) begin n_err++; $display("FAIL irq_ack: got w=%b addr=%h data=%h want 1/%h/0", bus1.MemWrite, bus1.address, bus1.data, AKA); end
        bus1.TimerInterrupt = 1'b0;
        bus1.cycle = 32'd151;
        step();
        n_cmp++; if (tick1 !== 32'd1) begin n_err++; $display("FAIL irq_tick: got %0d want 1", tick1); end
        n_cmp++; if (bus1.MemRead !== 1'b1 || bus1.MemWrite !== 1'b0) begin n_err++; $display("FAIL irq_reread: got r=%b w=%b want 1/0", bus1.MemRead, bus1.MemWrite); end
        bus1.cycle = 32'd152;
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.data !== 32'd250) begin n_err++; $display("FAIL irq_rearm_data: got w=%b data=%0d want 1/250", bus1.MemWrite, bus1.data); end
        step();
        n_cmp++; if (ovr1 !== 1'b0) begin n_err++; $display("FAIL irq_no_overrun: got %b want 0", ovr1); end
    endtask

    task automatic test_enable_drop();
        enable1 = 1'b0;
        step();
        n_cmp++; if (st1 !== 3'd0 || busy1 !== 1'b0) begin n_err++; $display("FAIL drop_wait_idle: got state=%0d busy=%b want 0/0", st1, busy1); end
        n_cmp++; if (bus1.MemRead !== 1'b0 || bus1.MemWrite !== 1'b0 || bus1.address !== 32'd0) begin n_err++; $display("FAIL drop_wait_bus: got r=%b w=%b addr=%h want 0/0/0", bus1.MemRead, bus1.MemWrite, bus1.address); end
        enable1 = 1'b1;
        bus1.cycle = 32'd400;
        step();
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.data !== 32'd500) begin n_err++; $display("FAIL drop_restart_data: got w=%b data=%0d want 1/500", bus1.MemWrite, bus1.data); end
        step();
        bus1.TimerInterrupt = 1'b1;
        enable1 = 1'b0;
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.address !== AKA) begin n_err++; $display("FAIL drop_pending_ack: got w=%b addr=%h want 1/%h", bus1.MemWrite, bus1.address, AKA); end
        bus1.TimerInterrupt = 1'b0;
        step();
        n_cmp++; if (st1 !== 3'd0 || tick1 !== 32'd2 || bus1.MemWrite !== 1'b0) begin n_err++; $display("FAIL drop_pending_idle: got state=%0d tick=%0d w=%b want 0/2/0", st1, tick1, bus1.MemWrite); end
        step();
        n_cmp++; if (bus1.MemRead !== 1'b0 || bus1.MemWrite !== 1'b0) begin n_err++; $display("FAIL drop_stays_idle: got r=%b w=%b want 0/0", bus1.MemRead, bus1.MemWrite); end
    endtask

    task automatic test_wrap();
        enable1 = 1'b1;
        bus1.cycle = 32'hffffffc0;
        step();
        step();
        n_cmp++; if (bus1.data !== 32'h00000024) begin n_err++; $display("FAIL wrap_first_target: got %h want 00000024", bus1.data); end
        step();
        bus1.cycle = 32'h00000024;
        bus1.TimerInterrupt = 1'b1;
        step();
        n_cmp++; if (bus1.MemWrite !== 1'b1 || bus1.address !== AKA) begin n_err++; $display("FAIL wrap_ack: got w=%b addr=%h", bus1.MemWrite, bus1.address); end
        bus1.TimerInterrupt = 1'b0;
        bus1.cycle = 32'h00000025;
        step();
        bus1.cycle = 32'h00000026;
        step();
        n_cmp++; if (bus1.data !== 32'h00000088) begin n_err++; $display("FAIL wrap_second_target: got %h want 00000088", bus1.data); end
        n_cmp++; if (ovr1 !== 1'b0 || tick1 !== 32'd3) begin n_err++; $display("FAIL wrap_status: got ovr=%b tick=%0d want 0/3", ovr1, tick1); end
    endtask

    task automatic test_reset_mid_arm();
        n_cmp++; if (st1 !== 3'd2) begin n_err++; $display("FAIL rst_pre_arm: got state %0d want 2", st1); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus1.MemWrite !== 1'b0 || bus1.address !== 32'd0 || bus1.data !== 32'd0) begin n_err++; $display("FAIL rst_async_bus: got w=%b addr=%h data=%h want 0/0/0", bus1.MemWrite, bus1.address, bus1.data); end
        n_cmp++; if (tick1 !== 32'd0 || busy1 !== 1'b0 || st1 !== 3'd0) begin n_err++; $display("FAIL rst_async_status: got tick=%0d busy=%b state=%0d want 0/0/0", tick1, busy1, st1); end
        @(posedge clock);
        #1;
        n_cmp++; if (bus1.MemWrite !== 1'b0 || st1 !== 3'd0) begin n_err++; $display("FAIL rst_no_write: got w=%b state=%0d want 0/0", bus1.MemWrite, st1); end
        enable1 = 1'b0;
        reset = 1'b1;
        step();
        n_cmp++; if (st1 !== 3'd0 || tick1 !== 32'd0) begin n_err++; $display("FAIL rst_after: got state=%0d tick=%0d want 0/0", st1, tick1); end
    endtask

    task automatic test_overrun();
        enable2 = 1'b1;
        bus2.cycle = 32'd100;
        step();
        step();
        n_cmp++; if (bus2.data !== 32'd104) begin n_err++; $display("FAIL ovr_first_target: got %0d want 104", bus2.data); end
        step();
        bus2.TimerInterrupt = 1'b1;
        step();
        bus2.TimerInterrupt = 1'b0;
        bus2.cycle = 32'd120;
        step();
        step();
        n_cmp++; if (bus2.data !== 32'd124 || ovr2 !== 1'b0) begin n_err++; $display("FAIL ovr_late_target: got data=%0d ovr=%b want 124/0", bus2.data, ovr2); end
        step();
        n_cmp++; if (ovr2 !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ovr2); end
        bus2.TimerInterrupt = 1'b1;
        step();
        bus2.TimerInterrupt = 1'b0;
        bus2.cycle = 32'd125;
        step();
        step();
        n_cmp++; if (bus2.data !== 32'd128) begin n_err++; $display("FAIL ovr_ontime_target: got %0d want 128", bus2.data); end
        step();
        n_cmp++; if (ovr2 !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", ovr2); end
        bus2.TimerInterrupt = 1'b1;
        step();
        bus2.TimerInterrupt = 1'b0;
        bus2.cycle = 32'd132;
        step();
        step();
        n_cmp++; if (bus2.data !== 32'd136) begin n_err++; $display("FAIL ovr_equal_target: got %0d want 136", bus2.data); end
        n_cmp++; if (tick2 !== 32'd3) begin n_err++; $display("FAIL ovr_tick: got %0d want 3", tick2); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        enable1 = 1'b0;
        enable2 = 1'b0;
        bus1.cycle = 32'd0;
        bus1.TimerInterrupt = 1'b0;
        bus2.cycle = 32'd0;
        bus2.TimerInterrupt = 1'b0;
        test_reset();
        test_start();
        test_interrupt();
        test_enable_drop();
        test_wrap();
        test_reset_mid_arm();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_tick_master.md
# timer_tick_master

Bus-initiator block that drives the memory-mapped cycle timer to produce a drift-free periodic tick without CPU involvement. It reads the timer's cycle counter, programs the interrupt-cycle register, waits for `TimerInterrupt`, acknowledges it, and re-arms one `PERIOD` later. It sits on the same data/address/MemRead/MemWrite bus as the timer, in place of the processor, when a hardware heartbeat is needed.

## Interface
- `PERIOD`, 32'd100: tick spacing in cycles; legal range 4 .. 2^31-1.
- `CYCLE_ADDR`, 32'hffff001c: timer cycle read / interrupt-cycle write address.
- `ACK_ADDR`, 32'hffff006c: timer acknowledge address.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `enable`  in  1  1 = run periodic ticking; 0 = stop after current bus operation.
- `TimerInterrupt`  in  1  interrupt line from timer.
- `cycle`  in  32  read data from timer, valid in the same cycle as MemRead to `CYCLE_ADDR`.
- `address`  out  32  bus address.
- `data`  out  32  bus write data.
- `MemRead`  out  1  bus read strobe.
- `MemWrite`  out  1  bus write strobe; target samples on the rising edge.
- `tick_count`  out  32  number of acknowledged interrupts, wraps mod 2^32.
- `overrun`  out  1  sticky; set when a computed target was already in the past.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- Moore FSM: IDLE, READ, ARM, WAIT, ACK. Bus outputs decoded from state and registers only.
- IDLE: all strobes 0, address 0, data 0. If `enable`=1 -> READ.
- READ: address=`CYCLE_ADDR`, MemRead=1; capture `cycle` into `now`. -> ARM.
- ARM: address=`CYCLE_ADDR`, MemWrite=1, data=`next`. `target` <= `next`, `armed` <= 1. -> WAIT.
  - `armed`=0: `next` = `now`+PERIOD.
  - `armed`=1: `cand` = `target`+PERIOD; if (`cand`-`now`) as 32-bit signed is <= 0, `next` = `now`+PERIOD and `overrun` <= 1; else `next` = `cand`.
- WAIT: no strobes. `TimerInterrupt`=1 -> ACK (takes priority over `enable`). Else `enable`=0 -> IDLE, `armed` <= 0.
- ACK: address=`ACK_ADDR`, MemWrite=1, data=0; `tick_count` += 1. `enable`=1 -> READ; else -> IDLE, `armed` <= 0.
- `enable` is sampled only in IDLE, WAIT and ACK; READ->ARM always completes.
- All additions/subtractions are 32-bit, mod 2^32; wrap of the timer counter past 32'hffffffff is handled by the signed-difference compare.

## Timing
- Reset (`reset`=0, async): state IDLE, `address`=0, `data`=0, MemRead=0, MemWrite=0, `tick_count`=0, `overrun`=0, `busy`=0, `armed`=0, `target`=0, `now`=0. Reset mid-operation abandons any bus cycle with no partial write.
- Start: `enable` high in IDLE -> READ on next edge; first ARM write 2 cycles after leaving IDLE.
- Interrupt service: `TimerInterrupt` seen in WAIT -> ACK next cycle (1 cycle), READ, ARM; new target written 3 edges after the interrupt is first sampled.
- Timer clears `TimerInterrupt` on the ACK edge; WAIT is never re-entered before READ/ARM, so a stale interrupt cannot cause a double ACK.
- Each strobe is asserted for exactly one cycle; MemRead and MemWrite are never both 1.
- Steady state: ARM writes targets T0+PERIOD, T0+2*PERIOD, ... with no accumulated drift.

## Test plan
- Reset, `enable`=1, timer at cycle 50, PERIOD=100 -> READ at 0xffff001c, then MemWrite data=150 to 0xffff001c; `busy`=1.
- Interrupt at cycle 150 -> MemWrite to 0xffff006c next cycle, `tick_count`=1, next ARM data=250 (not read-cycle+100).
- Counter starts at 32'hffffffc0, PERIOD=100 -> first target 32'h00000024; interrupt at that cycle serviced, `overrun`=0.
- Interrupt held off (timer stalled) until `cand` < `now`: PERIOD=4, target=104, ARM at now=120 -> data=124, `overrun`=1 and stays 1.
- `enable` dropped in WAIT with no interrupt -> IDLE next cycle, no strobes; dropped while interrupt pending -> one ACK write, then IDLE.
- `reset` pulsed low during ARM -> all outputs 0 immediately, no write observed at the following edge, `tick_count`=0.
